// File: rtl/junction_cycle_controller_pkg.sv
// Shared types and width derivations for the junction cycle controller
// and the UP processor set.
package junction_cycle_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_STALL,
      ST_DRAIN,
      ST_DONE
   } jcc_state_t;

   function automatic int unsigned calc_cpc(input int unsigned p, input int unsigned fo,
                                            input int unsigned z);
      return (p * fo) / z;
   endfunction

   function automatic int unsigned calc_cpc_w(input int unsigned cpc);
      return $clog2(cpc);
   endfunction

   function automatic int unsigned calc_etapos_w(input int unsigned frac_bits);
      return $clog2(frac_bits + 2);
   endfunction

   localparam int unsigned FRAC_BITS_DEFAULT = 10;
   localparam int unsigned ETAPOS_W          = calc_etapos_w(FRAC_BITS_DEFAULT);

endpackage

// File: rtl/junction_cycle_controller_eta_scheduler.sv
// Learning-rate schedule: etapos_reg steps up every ETA_DECAY_SAMPLES
// completed samples, saturating at frac_bits+1.
module eta_scheduler
   import junction_cycle_controller_pkg::*;
#(
   parameter int unsigned frac_bits         = 10,
   parameter int unsigned ETAPOS_INIT       = 3,
   parameter int unsigned ETA_DECAY_SAMPLES = 64
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                load,
   input  logic                                sample_done,
   output logic [calc_etapos_w(frac_bits)-1:0] etapos_reg
);

   localparam int unsigned EW = calc_etapos_w(frac_bits);
   localparam int unsigned DW = (ETA_DECAY_SAMPLES > 1) ? $clog2(ETA_DECAY_SAMPLES) : 1;
   localparam logic [DW-1:0] DEC_LAST = DW'(ETA_DECAY_SAMPLES - 1);
   localparam logic [EW-1:0] E_MAX    = EW'(frac_bits + 1);
   localparam logic [EW-1:0] E_INIT   = EW'(ETAPOS_INIT);

   logic [DW-1:0] decay_cnt;

   // decay_cnt wraps on every multiple of ETA_DECAY_SAMPLES completions
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         decay_cnt  <= '0;
         etapos_reg <= '0;
      end else if (load) begin
         decay_cnt  <= '0;
         etapos_reg <= E_INIT;
      end else if (sample_done) begin
         if (decay_cnt == DEC_LAST) begin
            decay_cnt <= '0;
            if (etapos_reg < E_MAX) etapos_reg <= etapos_reg + 1'b1;
         end else begin
            decay_cnt <= decay_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/junction_cycle_controller.sv
// Sequencer for one junction's FF/BP/UP sets: steps the edge window through
// each sample, counts samples, and schedules the UP-set learning rate.
module junction_cycle_controller
   import junction_cycle_controller_pkg::*;
#(
   parameter int unsigned p                 = 16,
   parameter int unsigned n                 = 8,
   parameter int unsigned z                 = 8,
   parameter int unsigned fo                = 2,
   parameter int unsigned fi                = 4,
   parameter int unsigned frac_bits         = 10,
   parameter int unsigned ETAPOS_INIT       = 3,
   parameter int unsigned ETA_DECAY_SAMPLES = 64
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       start,
   input  logic                                       train,
   input  logic [15:0]                                num_samples,
   input  logic                                       sample_ready,
   output logic                                       ff_en,
   output logic                                       bp_en,
   output logic                                       up_en,
   output logic [calc_cpc_w(calc_cpc(p, fo, z))-1:0]  cycle_index,
   output logic                                       act_valid,
   output logic [calc_cpc_w(calc_cpc(p, fo, z))-1:0]  act_index,
   output logic [calc_etapos_w(frac_bits)-1:0]        etapos,
   output logic [15:0]                                sample_count,
   output logic                                       busy,
   output logic                                       done
);

   localparam int unsigned CPC   = calc_cpc(p, fo, z);
   localparam int unsigned CPC_W = calc_cpc_w(CPC);
   localparam int unsigned EW    = calc_etapos_w(frac_bits);
   localparam logic [CPC_W-1:0] LAST_IDX = CPC_W'(CPC - 1);

   if ((p * fo) % z != 0) begin : g_chk_div
      $error("p*fo must be a multiple of z");
   end
   if (p * fo != n * fi) begin : g_chk_edges
      $error("p*fo must equal n*fi");
   end
   if (CPC < 2) begin : g_chk_cpc
      $error("cycles per sample must be at least 2");
   end
   if (ETAPOS_INIT > frac_bits + 1) begin : g_chk_eta
      $error("ETAPOS_INIT exceeds frac_bits+1");
   end

   jcc_state_t       state, state_d;
   logic             train_q, train_d;
   logic [15:0]      nsamp_q, nsamp_d;
   logic [CPC_W-1:0] cidx_d;
   logic [15:0]      count_d;
   logic             sample_done;
   logic             load_eta;
   logic [EW-1:0]    etapos_reg;

   always_comb begin
      state_d     = state;
      train_d     = train_q;
      nsamp_d     = nsamp_q;
      cidx_d      = cycle_index;
      count_d     = sample_count;
      sample_done = 1'b0;
      load_eta    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               train_d  = train;
               nsamp_d  = num_samples;
               cidx_d   = '0;
               count_d  = '0;
               load_eta = 1'b1;
               state_d  = (num_samples == 16'd0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (cycle_index == LAST_IDX) begin
               cidx_d      = '0;
               count_d     = sample_count + 16'd1;
               sample_done = 1'b1;
               if (count_d == nsamp_q)  state_d = ST_DRAIN;
               else if (!sample_ready)  state_d = ST_STALL;
            end else begin
               cidx_d = cycle_index + 1'b1;
            end
         end
         ST_STALL: if (sample_ready) state_d = ST_RUN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Enables/busy/done are registered from the next state so they line up
   // with the cycle the state is entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         train_q      <= 1'b0;
         nsamp_q      <= '0;
         cycle_index  <= '0;
         sample_count <= '0;
         ff_en        <= 1'b0;
         bp_en        <= 1'b0;
         up_en        <= 1'b0;
         act_valid    <= 1'b0;
         act_index    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         train_q      <= train_d;
         nsamp_q      <= nsamp_d;
         cycle_index  <= cidx_d;
         sample_count <= count_d;
         ff_en        <= (state_d == ST_RUN);
         bp_en        <= (state_d == ST_RUN) && train_d;
         up_en        <= (state_d == ST_RUN) && train_d;
         act_valid    <= ff_en;
         act_index    <= cycle_index;
         busy         <= (state_d != ST_IDLE);
         done         <= (state_d == ST_DONE);
      end
   end

   eta_scheduler #(
      .frac_bits         (frac_bits),
      .ETAPOS_INIT       (ETAPOS_INIT),
      .ETA_DECAY_SAMPLES (ETA_DECAY_SAMPLES)
   ) u_eta (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (load_eta),
      .sample_done (sample_done),
      .etapos_reg  (etapos_reg)
   );

   assign etapos = up_en ? etapos_reg : '0;

endmodule

// File: tb/tb_junction_cycle_controller.sv
// Randomized bench for junction_cycle_controller; expected per-cycle traces
// are built from the run description (samples, stalls, eta schedule).
module tb_junction_cycle_controller;

   localparam int unsigned P    = 16;
   localparam int unsigned NN   = 8;
   localparam int unsigned Z    = 8;
   localparam int unsigned FO   = 2;
   localparam int unsigned FI   = 4;
   localparam int unsigned FB   = 10;
   localparam int unsigned EINIT = 10;
   localparam int unsigned EDEC = 2;
   localparam int unsigned CPC  = 4;
   localparam int unsigned EMAX = FB + 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        train;
   logic [15:0] num_samples;
   logic        sample_ready;
   logic        ff_en, bp_en, up_en, act_valid, busy, done;
   logic [1:0]  cycle_index, act_index;
   logic [3:0]  etapos;
   logic [15:0] sample_count;

   typedef struct packed {
      logic        ff;
      logic        bp;
      logic        up;
      logic [1:0]  cidx;
      logic        av;
      logic [1:0]  aidx;
      logic [3:0]  eta;
      logic [15:0] cnt;
      logic        busy;
      logic        done;
   } out_t;

   out_t exp_q[$];
   out_t obs_q[$];
   bit   sr_q[$];
   int   stall_after[64];
   int   vectors = 0;
   int   miscompares = 0;
   bit   m_prev_ff;
   int   m_prev_cidx;

   junction_cycle_controller #(
      .p                 (P),
      .n                 (NN),
      .z                 (Z),
      .fo                (FO),
      .fi                (FI),
      .frac_bits         (FB),
      .ETAPOS_INIT       (EINIT),
      .ETA_DECAY_SAMPLES (EDEC)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .train        (train),
      .num_samples  (num_samples),
      .sample_ready (sample_ready),
      .ff_en        (ff_en),
      .bp_en        (bp_en),
      .up_en        (up_en),
      .cycle_index  (cycle_index),
      .act_valid    (act_valid),
      .act_index    (act_index),
      .etapos       (etapos),
      .sample_count (sample_count),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   function automatic out_t sample_dut();
      out_t o;
      o.ff = ff_en; o.bp = bp_en; o.up = up_en; o.cidx = cycle_index;
      o.av = act_valid; o.aidx = act_index; o.eta = etapos;
      o.cnt = sample_count; o.busy = busy; o.done = done;
      return o;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("ff%0b bp%0b up%0b ci%0d av%0b ai%0d eta%0d cnt%0d busy%0b done%0b",
                       o.ff, o.bp, o.up, o.cidx, o.av, o.aidx, o.eta, o.cnt, o.busy, o.done);
   endfunction

   // One expected cycle; act_valid/act_index are the previous cycle's ff/cidx.
   function automatic void push(input bit ff, input bit tr, input int cidx, input int eta,
                                input int cnt, input bit bsy, input bit dn, input bit sr);
      out_t o;
      o.ff = ff; o.bp = ff & tr; o.up = ff & tr; o.cidx = 2'(cidx);
      o.av = m_prev_ff; o.aidx = 2'(m_prev_cidx);
      o.eta = (ff & tr) ? 4'(eta) : 4'd0;
      o.cnt = 16'(cnt); o.busy = bsy; o.done = dn;
      exp_q.push_back(o);
      sr_q.push_back(sr);
      m_prev_ff = ff;
      m_prev_cidx = cidx;
   endfunction

   function automatic void build_trace(input bit tr, input int ns);
      int e;
      exp_q.delete(); sr_q.delete(); obs_q.delete();
      m_prev_ff = 1'b0; m_prev_cidx = 0;
      for (int s = 0; s < ns; s++) begin
         e = EINIT + s / EDEC;
         if (e > EMAX) e = EMAX;
         for (int c = 0; c < CPC; c++) begin
            if (c == CPC - 1 && s < ns - 1)
               push(1'b1, tr, c, e, s, 1'b1, 1'b0, stall_after[s] == 0);
            else
               push(1'b1, tr, c, e, s, 1'b1, 1'b0, 1'($urandom));
         end
         if (s < ns - 1)
            for (int k = 1; k <= stall_after[s]; k++)
               push(1'b0, tr, 0, 0, s + 1, 1'b1, 1'b0, k == stall_after[s]);
      end
      if (ns > 0) push(1'b0, tr, 0, 0, ns, 1'b1, 1'b0, 1'($urandom));
      push(1'b0, tr, 0, 0, ns, 1'b1, 1'b1, 1'($urandom));
      push(1'b0, tr, 0, 0, ns, 1'b0, 1'b0, 1'($urandom));
   endfunction

   // Entered just after a rising edge; captures one observation per trace cycle.
   task automatic drive_run(input bit tr, input int ns, input bit inject);
      start = 1'b1; train = tr; num_samples = 16'(ns);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         train = 1'($urandom);
         num_samples = 16'($urandom);
         obs_q.push_back(sample_dut());
         sample_ready = sr_q[i];
         if (inject && i < exp_q.size() - 2 && $urandom_range(0, 2) == 0) start = 1'b1;
      end
   endtask

   task automatic test_reset();
      out_t o;
      o = sample_dut();
      vectors++;
      if (o !== out_t'(0)) begin
         miscompares++;
         $display("FAIL reset: got %s want all zero", fmt(o));
      end
   endtask

   task automatic test_basic();
      foreach (stall_after[i]) stall_after[i] = 0;
      build_trace(1'b1, 2);
      drive_run(1'b1, 2, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL basic cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_inference();
      foreach (stall_after[i]) stall_after[i] = 0;
      build_trace(1'b0, 1);
      drive_run(1'b0, 1, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL inference cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_stall();
      foreach (stall_after[i]) stall_after[i] = 0;
      stall_after[0] = 5;
      build_trace(1'b1, 3);
      drive_run(1'b1, 3, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL stall cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_eta_decay();
      foreach (stall_after[i]) stall_after[i] = 0;
      stall_after[1] = 2;
      build_trace(1'b1, 8);
      drive_run(1'b1, 8, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL eta_decay cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_zero_samples();
      build_trace(1'($urandom), 0);
      drive_run(1'b1, 0, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL zero_samples cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_start_ignored();
      foreach (stall_after[i]) stall_after[i] = 0;
      stall_after[1] = 3;
      build_trace(1'b1, 4);
      drive_run(1'b1, 4, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL start_ignored cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_reset_mid_run();
      out_t o;
      start = 1'b1; train = 1'b1; num_samples = 16'd4; sample_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1 o = sample_dut();
      vectors++;
      if (o !== out_t'(0)) begin
         miscompares++;
         $display("FAIL reset_mid_run async: got %s want all zero", fmt(o));
      end
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      o = sample_dut();
      vectors++;
      if (o !== out_t'(0)) begin
         miscompares++;
         $display("FAIL reset_mid_run idle: got %s want all zero", fmt(o));
      end
      foreach (stall_after[i]) stall_after[i] = 0;
      build_trace(1'b1, 2);
      drive_run(1'b1, 2, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL reset_mid_run restart cyc %0d: got %s want %s", i, fmt(obs_q[i]), fmt(exp_q[i]));
         end
      end
   endtask

   task automatic test_random();
      bit tr;
      int ns;
      for (int r = 0; r < 12; r++) begin
         tr = 1'($urandom);
         ns = $urandom_range(0, 7);
         foreach (stall_after[i]) stall_after[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
         build_trace(tr, ns);
         drive_run(tr, ns, 1'($urandom));
         for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL random run %0d ns %0d cyc %0d: got %s want %s",
                        r, ns, i, fmt(obs_q[i]), fmt(exp_q[i]));
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; train = 1'b0; num_samples = '0; sample_ready = 1'b1;
      #12;
      test_reset();
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_inference();
      test_stall();
      test_eta_decay();
      test_zero_samples();
      test_start_ignored();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
